ez90_issue_window: RTL and testbench

Parametrised successor to the eZ90 single-slot scheduler: a buffered, age-ordered issue window. It accepts up to NUM_SRC tagged uops per cycle from the dispatch sources (RS, LSQ, ...) and issues up to one uop per functional unit per cycle, oldest-first, to the INT/BR/MD/VEC/MEM units. It sits between the rename/dispatch stage and the functional units, replacing the zero-depth combinational select with real buffering and parallel multi-FU issue.

---
 rtl/ez90_issue_window.sv | 176 +++++++++++++++++
 tb/tb_ez90_issue_window.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ez90_issue_window.sv
// Age-ordered multi-FU issue window: collapsing queue with entry 0 the oldest.
// Accepts up to NUM_SRC uops per cycle and issues the oldest ready uop per FU.

package ez90_pkg;
    localparam logic [2:0] EZ90_FU_ALU    = 3'd0;
    localparam logic [2:0] EZ90_FU_MEM    = 3'd1;
    localparam logic [2:0] EZ90_FU_BRANCH = 3'd2;
    localparam logic [2:0] EZ90_FU_MULDIV = 3'd3;
    localparam logic [2:0] EZ90_FU_VEC    = 3'd5;

    typedef struct packed {
        logic [7:0]  tag;
        logic [2:0]  fu;
        logic [15:0] payload;
    } ez90_uop_tagged_t;
endpackage

module ez90_issue_window
    import ez90_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int NUM_SRC = 2,
    localparam int NUM_FU  = 5,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NUM_SRC-1:0]    in_valid,
    input  ez90_uop_tagged_t      in_uop [NUM_SRC],
    output logic [NUM_SRC-1:0]    in_ready,
    output logic [NUM_FU-1:0]     fu_valid,
    output ez90_uop_tagged_t      fu_uop [NUM_FU],
    input  logic [NUM_FU-1:0]     fu_ready,
    output logic [CW-1:0]         count,
    output logic                  empty
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    ez90_uop_tagged_t  uop_q    [DEPTH];
    ez90_uop_tagged_t  uop_d    [DEPTH];
    logic [2:0]        fu_idx_q [DEPTH];
    logic [2:0]        fu_idx_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;

    logic [NUM_FU-1:0] sel_found;
    logic [IW-1:0]     sel_idx [NUM_FU];
    logic [NUM_FU-1:0] grant;
    logic [DEPTH-1:0]  issued;
    logic [NUM_SRC-1:0] accept;
    logic [CW-1:0]     free_slots;
    logic [DEPTH-1:0]  occ_mask;

    function automatic logic [2:0] decode_fu(input logic [2:0] code);
        case (code)
            EZ90_FU_ALU:    return 3'd0;
            EZ90_FU_BRANCH: return 3'd1;
            EZ90_FU_MULDIV: return 3'd2;
            EZ90_FU_VEC:    return 3'd3;
            EZ90_FU_MEM:    return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    // Oldest-first select per FU; scanning downward leaves the lowest index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_sel
            logic          found;
            logic [IW-1:0] idx;

            always_comb begin
                found = 1'b0;
                idx   = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (valid_q[i] && (fu_idx_q[i] == 3'(gi))) begin
                        found = 1'b1;
                        idx   = IW'(i);
                    end
                end
            end

            assign sel_found[gi] = found;
            assign sel_idx[gi]   = idx;
            assign fu_valid[gi]  = found && !flush;
            assign fu_uop[gi]    = found ? uop_q[idx] : '0;
            assign grant[gi]     = fu_valid[gi] && fu_ready[gi];
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_issue
            logic hit;

            always_comb begin
                hit = 1'b0;
                for (int f = 0; f < NUM_FU; f++) begin
                    if (grant[f] && (sel_idx[f] == IW'(gi))) begin
                        hit = 1'b1;
                    end
                end
            end

            assign issued[gi]   = valid_q[gi] && hit;
            assign occ_mask[gi] = (CW'(gi) < count_q);
        end

        // Readiness looks only at the registered occupancy.
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign in_ready[gi] = !rst && !flush && (free_slots > CW'(gi));
        end
    endgenerate

    assign free_slots = CW'(DEPTH) - count_q;
    assign accept     = in_valid & in_ready;

    // Survivors slide down in order, then accepted sources append in index order.
    always_comb begin
        logic [CW-1:0] wr;
        valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            uop_d[i]    = '0;
            fu_idx_d[i] = '0;
        end
        wr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !issued[i] && (wr < CW'(DEPTH))) begin
                valid_d[wr[IW-1:0]]  = 1'b1;
                uop_d[wr[IW-1:0]]    = uop_q[i];
                fu_idx_d[wr[IW-1:0]] = fu_idx_q[i];
                wr = wr + CW'(1);
            end
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            if (accept[s] && (wr < CW'(DEPTH))) begin
                valid_d[wr[IW-1:0]]  = 1'b1;
                uop_d[wr[IW-1:0]]    = in_uop[s];
                fu_idx_d[wr[IW-1:0]] = decode_fu(in_uop[s].fu);
                wr = wr + CW'(1);
            end
        end
        count_d = wr;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                uop_q[i]    <= '0;
                fu_idx_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                uop_q[i]    <= uop_d[i];
                fu_idx_q[i] <= fu_idx_d[i];
            end
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);

    // Occupied entries always form a contiguous run starting at entry 0.
    a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
    a_contiguous:  assert property (@(posedge clk) disable iff (rst) valid_q == occ_mask);

    logic unused_sel;
    assign unused_sel = ^sel_found;

endmodule

// File: tb/tb_ez90_issue_window.sv
// Randomized and directed bench for ez90_issue_window against a queue-based model.
module tb_ez90_issue_window;
    import ez90_pkg::*;

    localparam int DEPTH   = 8;
    localparam int NUM_SRC = 2;
    localparam int NUM_FU  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [1:0]       in_valid = '0;
    ez90_uop_tagged_t in_uop [NUM_SRC];
    logic [1:0]       in_ready;
    logic [4:0]       fu_valid;
    ez90_uop_tagged_t fu_uop [NUM_FU];
    logic [4:0]       fu_ready = '0;
    logic [3:0]       count;
    logic             empty;

    int errors = 0;
    int checks = 0;

    ez90_issue_window #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_uop   (in_uop),
        .in_ready (in_ready),
        .fu_valid (fu_valid),
        .fu_uop   (fu_uop),
        .fu_ready (fu_ready),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    function automatic ez90_uop_tagged_t mk(input logic [7:0] tag, input logic [2:0] fu);
        ez90_uop_tagged_t u;
        u.tag     = tag;
        u.fu      = fu;
        u.payload = 16'($urandom);
        return u;
    endfunction

    // FU routing rule: named codes map to their unit, everything else is INT.
    function automatic int fu_of(input logic [2:0] code);
        if (code == EZ90_FU_BRANCH) return 1;
        if (code == EZ90_FU_MULDIV) return 2;
        if (code == EZ90_FU_VEC)    return 3;
        if (code == EZ90_FU_MEM)    return 4;
        return 0;
    endfunction

    task automatic drain_window();
        fu_ready = 5'b11111;
        in_valid = '0;
        for (int n = 0; n < 20 && count != 0; n++) @(negedge clk);
        fu_ready = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (fu_valid !== 5'b0) begin errors++; $display("FAIL reset_fu_valid: got %b want 00000", fu_valid); end
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL reset_in_ready: got %b want 00", in_ready); end
        for (int f = 0; f < NUM_FU; f++) begin
            checks++; if (fu_uop[f] !== '0) begin errors++; $display("FAIL reset_fu_uop%0d: got %h want 0", f, fu_uop[f]); end
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL release_in_ready: got %b want 11", in_ready); end
        $display("reset: released, in_ready=%b count=%0d", in_ready, count);
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid  = 2'b01;
        in_uop[0] = mk(8'd5, EZ90_FU_ALU);
        @(negedge clk);
        in_valid = '0;
        #1;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
        checks++; if (fu_valid !== 5'b00001) begin errors++; $display("FAIL basic_fu_valid: got %b want 00001", fu_valid); end
        checks++; if (fu_uop[0].tag !== 8'd5) begin errors++; $display("FAIL basic_tag: got %0d want 5", fu_uop[0].tag); end
        fu_ready = 5'b00001;
        @(negedge clk);
        fu_ready = '0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_drain_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", empty); end
        $display("basic: INT tag 5 enqueued and issued");
    endtask

    task automatic test_age_order();
        @(negedge clk);
        in_valid  = 2'b11;
        in_uop[0] = mk(8'd1, EZ90_FU_MEM);
        in_uop[1] = mk(8'd2, EZ90_FU_MEM);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = '0;
            #1;
            checks++; if (fu_valid[4] !== 1'b1) begin errors++; $display("FAIL age_hold_valid c%0d: got %b want 1", k, fu_valid[4]); end
            checks++; if (fu_uop[4].tag !== 8'd1) begin errors++; $display("FAIL age_hold_tag c%0d: got %0d want 1", k, fu_uop[4].tag); end
        end
        fu_ready = 5'b10000;
        @(negedge clk);
        #1;
        checks++; if (fu_uop[4].tag !== 8'd2) begin errors++; $display("FAIL age_second_tag: got %0d want 2", fu_uop[4].tag); end
        @(negedge clk);
        fu_ready = '0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL age_empty: got %b want 1", empty); end
        $display("age_order: MEM tags 1 then 2 issued");
    endtask

    task automatic test_parallel_issue();
        @(negedge clk);
        in_valid = 2'b11; in_uop[0] = mk(8'd10, EZ90_FU_ALU);    in_uop[1] = mk(8'd11, EZ90_FU_BRANCH);
        @(negedge clk);
        in_valid = 2'b11; in_uop[0] = mk(8'd12, EZ90_FU_MULDIV); in_uop[1] = mk(8'd13, EZ90_FU_VEC);
        @(negedge clk);
        in_valid = 2'b01; in_uop[0] = mk(8'd14, EZ90_FU_MEM);
        @(negedge clk);
        in_valid = '0;
        #1;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL par_count: got %0d want 5", count); end
        checks++; if (fu_valid !== 5'b11111) begin errors++; $display("FAIL par_fu_valid: got %b want 11111", fu_valid); end
        for (int f = 0; f < NUM_FU; f++) begin
            checks++; if (fu_uop[f].tag !== 8'(10 + f)) begin errors++; $display("FAIL par_tag%0d: got %0d want %0d", f, fu_uop[f].tag, 10 + f); end
        end
        fu_ready = 5'b11111;
        @(negedge clk);
        fu_ready = '0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL par_after_count: got %0d want 0", count); end
        checks++; if (fu_valid !== 5'b0) begin errors++; $display("FAIL par_after_valid: got %b want 00000", fu_valid); end
        $display("parallel_issue: five FUs issued in one cycle");
    endtask

    task automatic test_full_backpressure();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid  = 2'b11;
            in_uop[0] = mk(8'(20 + 2 * k), EZ90_FU_ALU);
            in_uop[1] = mk(8'(21 + 2 * k), EZ90_FU_ALU);
        end
        @(negedge clk);
        in_valid  = 2'b11;
        in_uop[0] = mk(8'd90, EZ90_FU_ALU);
        in_uop[1] = mk(8'd91, EZ90_FU_ALU);
        #1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", count); end
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL full_in_ready: got %b want 00", in_ready); end
        fu_ready = 5'b00001;
        #1;
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL full_same_cycle_ready: got %b want 00", in_ready); end
        checks++; if (fu_uop[0].tag !== 8'd20) begin errors++; $display("FAIL full_head_tag: got %0d want 20", fu_uop[0].tag); end
        @(negedge clk);
        fu_ready = '0;
        in_valid = '0;
        #1;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_count: got %0d want 7", count); end
        checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL full_after_ready: got %b want 01", in_ready); end
        checks++; if (fu_uop[0].tag !== 8'd21) begin errors++; $display("FAIL full_next_tag: got %0d want 21", fu_uop[0].tag); end
        drain_window();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain: got count %0d want 0", count); end
        $display("full_backpressure: window filled to 8 and drained");
    endtask

    task automatic test_unknown_fu();
        @(negedge clk);
        in_valid  = 2'b11;
        in_uop[0] = mk(8'd40, 3'd6);
        in_uop[1] = mk(8'd41, 3'd7);
        @(negedge clk);
        in_valid = '0;
        #1;
        checks++; if (fu_valid !== 5'b00001) begin errors++; $display("FAIL unk_fu_valid: got %b want 00001", fu_valid); end
        checks++; if (fu_uop[0].tag !== 8'd40) begin errors++; $display("FAIL unk_tag0: got %0d want 40", fu_uop[0].tag); end
        fu_ready = 5'b00001;
        @(negedge clk);
        #1;
        checks++; if (fu_uop[0].tag !== 8'd41) begin errors++; $display("FAIL unk_tag1: got %0d want 41", fu_uop[0].tag); end
        @(negedge clk);
        fu_ready = '0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unk_empty: got %b want 1", empty); end
        $display("unknown_fu: codes 6 and 7 issued on INT");
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid  = 2'b11;
            in_uop[0] = mk(8'(50 + 2 * k), EZ90_FU_MEM);
            in_uop[1] = mk(8'(51 + 2 * k), EZ90_FU_BRANCH);
        end
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 2'b11;
        fu_ready = 5'b11111;
        #1;
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL flush_pre_count: got %0d want 6", count); end
        checks++; if (fu_valid !== 5'b0) begin errors++; $display("FAIL flush_fu_valid: got %b want 00000", fu_valid); end
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL flush_in_ready: got %b want 00", in_ready); end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = '0;
        fu_ready = '0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (fu_valid !== 5'b0) begin errors++; $display("FAIL flush_after_valid: got %b want 00000", fu_valid); end
        $display("flush: six entries killed, inputs dropped");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid  = 2'b11;
        in_uop[0] = mk(8'd60, EZ90_FU_ALU);
        in_uop[1] = mk(8'd61, EZ90_FU_MEM);
        @(negedge clk);
        in_uop[0] = mk(8'd62, EZ90_FU_ALU);
        in_uop[1] = mk(8'd63, EZ90_FU_VEC);
        #1;
        checks++; if (fu_valid !== 5'b10001) begin errors++; $display("FAIL arst_pre_valid: got %b want 10001", fu_valid); end
        #1;
        rst = 1'b1;
        fu_ready = 5'b11111;
        #1;
        checks++; if (fu_valid !== 5'b0) begin errors++; $display("FAIL arst_fu_valid: got %b want 00000", fu_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", count); end
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL arst_in_ready: got %b want 00", in_ready); end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '0;
        fu_ready = '0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_after_count: got %0d want 0", count); end
        $display("async_reset: window cleared mid-burst");
    endtask

    task automatic test_random();
        ez90_uop_tagged_t mq[$];
        ez90_uop_tagged_t nq[$];
        ez90_uop_tagged_t exp_uop;
        int               sel [NUM_FU];
        logic [1:0]       exp_ready;
        logic [4:0]       exp_valid;
        logic [7:0]       tag_ctr;
        bit               keep;
        int               issues;
        tag_ctr = 8'd100;
        issues  = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            flush    = ($urandom_range(0, 39) == 0);
            in_valid = 2'($urandom);
            for (int s = 0; s < NUM_SRC; s++) begin
                in_uop[s] = mk(tag_ctr, 3'($urandom));
                tag_ctr++;
            end
            fu_ready = 5'($urandom);
            #1;
            for (int s = 0; s < NUM_SRC; s++) exp_ready[s] = !flush && ((DEPTH - mq.size()) > s);
            for (int f = 0; f < NUM_FU; f++) begin
                sel[f] = -1;
                for (int j = 0; j < mq.size(); j++) begin
                    if (sel[f] < 0 && fu_of(mq[j].fu) == f) sel[f] = j;
                end
                exp_valid[f] = (sel[f] >= 0) && !flush;
            end
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_ready); end
            checks++; if (fu_valid !== exp_valid) begin errors++; $display("FAIL rnd_fu_valid c%0d: got %b want %b", cyc, fu_valid, exp_valid); end
            checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, count, mq.size()); end
            checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty c%0d: got %b want %b", cyc, empty, mq.size() == 0); end
            for (int f = 0; f < NUM_FU; f++) begin
                if (sel[f] >= 0) exp_uop = mq[sel[f]];
                else             exp_uop = '0;
                checks++; if (fu_uop[f] !== exp_uop) begin errors++; $display("FAIL rnd_fu_uop%0d c%0d: got %h want %h", f, cyc, fu_uop[f], exp_uop); end
            end
            if (flush) begin
                mq.delete();
            end else begin
                nq.delete();
                for (int j = 0; j < mq.size(); j++) begin
                    keep = 1'b1;
                    for (int f = 0; f < NUM_FU; f++) begin
                        if (sel[f] == j && fu_ready[f]) keep = 1'b0;
                    end
                    if (keep) nq.push_back(mq[j]);
                    else      issues++;
                end
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (in_valid[s] && exp_ready[s]) nq.push_back(in_uop[s]);
                end
                mq = nq;
            end
        end
        flush = 1'b0;
        in_valid = '0;
        fu_ready = '0;
        $display("random: 600 cycles, %0d issues modelled", issues);
    endtask

    initial begin
        for (int s = 0; s < NUM_SRC; s++) in_uop[s] = '0;
        test_reset();
        test_basic();
        test_age_order();
        test_parallel_issue();
        test_full_backpressure();
        test_unknown_fu();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit reached");
    end

endmodule
